// File: rtl/consent_header_parser_pkg.sv
// Shared definitions for the consent packet header decoder: geometry constants,
// consent-state encoding and the packed header / decoded-output layouts.
package consent_pkg;

   localparam int BYTE_W      = 8;
   localparam int HDR_BYTES   = 18;
   localparam int HDR_W       = HDR_BYTES * BYTE_W;
   localparam int CKSUM_BYTES = 17;
   localparam int BYTE_CKSUM  = 17;

   typedef enum logic [1:0] {
      CONSENT_FULL       = 2'd0,
      CONSENT_DIMINISHED = 2'd1,
      CONSENT_SUSPENDED  = 2'd2,
      CONSENT_EMERGENCY  = 2'd3
   } consent_state_e;

   // Field order mirrors the wire format: byte 0 occupies the most significant bits.
   typedef struct packed {
      logic [31:0]    rpp_address;
      logic [31:0]    packet_id;
      logic [15:0]    origin_ref;
      consent_state_e cstate;
      logic           has_pma_link;
      logic           fallback_flag;
      logic [3:0]     reserved;
      logic [4:0]     phase_entropy_index;
      logic [2:0]     complecount_trace;
      logic [7:0]     payload_type;
      logic [7:0]     fallback_vector;
      logic [15:0]    coherence_window_id;
      logic [7:0]     phase_ref;
      logic [7:0]     checksum;
   } header_t;

   typedef struct packed {
      logic [31:0]    rpp_address;
      logic [31:0]    packet_id;
      logic [15:0]    origin_ref;
      consent_state_e cstate;
      logic           has_pma_link;
      logic           needs_fallback;
      logic [4:0]     phase_entropy_index;
      logic [2:0]     complecount_trace;
      logic [7:0]     payload_type;
      logic [7:0]     fallback_vector;
      logic [15:0]    coherence_window_id;
      logic [7:0]     phase_ref;
      logic           checksum_ok;
   } decoded_t;

   // LSB position of header byte idx within the big-endian header word.
   function automatic int byte_lsb(input int idx);
      return HDR_W - BYTE_W * (idx + 1);
   endfunction

   function automatic logic fallback_required(input consent_state_e cs, input logic flag);
      return flag || (cs == CONSENT_SUSPENDED) || (cs == CONSENT_EMERGENCY);
   endfunction

endpackage

// File: rtl/header_xor_checksum.sv
// Combinational 8-bit XOR reduction over the 17 checksummed header bytes.
module header_xor_checksum
   import consent_pkg::*;
(
   input  logic [CKSUM_BYTES*BYTE_W-1:0] i_bytes,
   output logic [BYTE_W-1:0]             o_xor
);

   logic [BYTE_W-1:0] w_byte [CKSUM_BYTES];

   for (genvar gi = 0; gi < CKSUM_BYTES; gi++) begin : g_byte
      assign w_byte[gi] = i_bytes[gi*BYTE_W +: BYTE_W];
   end

   always_comb begin
      o_xor = '0;
      for (int i = 0; i < CKSUM_BYTES; i++) begin
         o_xor = o_xor ^ w_byte[i];
      end
   end

endmodule

// File: rtl/consent_header_parser.sv
// Registered decoder for the 144-bit consent packet header: field slicing,
// routing flags and checksum status, one cycle of latency, no backpressure.
module consent_header_parser
   import consent_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [HDR_W-1:0]   header_in,
   output logic               out_valid,
   output logic [31:0]        rpp_address,
   output logic [31:0]        packet_id,
   output logic [15:0]        origin_ref,
   output logic [4:0]         theta,
   output logic [2:0]         phi,
   output logic [2:0]         omega,
   output logic [7:0]         radius,
   output logic [1:0]         consent_state,
   output logic               has_pma_link,
   output logic               needs_fallback,
   output logic [4:0]         phase_entropy_index,
   output logic [2:0]         complecount_trace,
   output logic [7:0]         payload_type,
   output logic [7:0]         fallback_vector,
   output logic [15:0]        coherence_window_id,
   output logic [7:0]         phase_ref,
   output logic               checksum_ok
);

   header_t           w_hdr;
   logic [BYTE_W-1:0] w_xor;
   logic [BYTE_W-1:0] w_cksum_byte;
   decoded_t          w_dec;
   decoded_t          r_dec;
   logic              r_out_valid;

   assign w_hdr        = header_t'(header_in);
   assign w_cksum_byte = header_in[byte_lsb(BYTE_CKSUM) +: BYTE_W];

   header_xor_checksum u_cksum (
      .i_bytes (header_in[HDR_W-1 -: CKSUM_BYTES*BYTE_W]),
      .o_xor   (w_xor)
   );

   // Reserved bits of byte 10 are dropped here; they still feed the checksum.
   always_comb begin
      w_dec                     = '0;
      w_dec.rpp_address         = w_hdr.rpp_address;
      w_dec.packet_id           = w_hdr.packet_id;
      w_dec.origin_ref          = w_hdr.origin_ref;
      w_dec.cstate              = w_hdr.cstate;
      w_dec.has_pma_link        = w_hdr.has_pma_link;
      w_dec.needs_fallback      = fallback_required(w_hdr.cstate, w_hdr.fallback_flag);
      w_dec.phase_entropy_index = w_hdr.phase_entropy_index;
      w_dec.complecount_trace   = w_hdr.complecount_trace;
      w_dec.payload_type        = w_hdr.payload_type;
      w_dec.fallback_vector     = w_hdr.fallback_vector;
      w_dec.coherence_window_id = w_hdr.coherence_window_id;
      w_dec.phase_ref           = w_hdr.phase_ref;
      w_dec.checksum_ok         = (w_xor == w_cksum_byte);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_dec       <= '0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_dec <= w_dec;
         end
      end
   end

   assign out_valid           = r_out_valid;
   assign rpp_address         = r_dec.rpp_address;
   assign packet_id           = r_dec.packet_id;
   assign origin_ref          = r_dec.origin_ref;
   assign theta               = r_dec.rpp_address[31:27];
   assign phi                 = r_dec.rpp_address[26:24];
   assign omega               = r_dec.rpp_address[23:21];
   assign radius              = r_dec.rpp_address[20:13];
   assign consent_state       = r_dec.cstate;
   assign has_pma_link        = r_dec.has_pma_link;
   assign needs_fallback      = r_dec.needs_fallback;
   assign phase_entropy_index = r_dec.phase_entropy_index;
   assign complecount_trace   = r_dec.complecount_trace;
   assign payload_type        = r_dec.payload_type;
   assign fallback_vector     = r_dec.fallback_vector;
   assign coherence_window_id = r_dec.coherence_window_id;
   assign phase_ref           = r_dec.phase_ref;
   assign checksum_ok         = r_dec.checksum_ok;

endmodule

// File: tb/tb_consent_header_parser.sv
// Randomized self-checking bench for consent_header_parser against a byte-level model.
module tb_consent_header_parser;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [143:0] header_in = '0;
   logic         out_valid;
   logic [31:0]  rpp_address, packet_id;
   logic [15:0]  origin_ref, coherence_window_id;
   logic [4:0]   theta, phase_entropy_index;
   logic [2:0]   phi, omega, complecount_trace;
   logic [7:0]   radius, payload_type, fallback_vector, phase_ref;
   logic [1:0]   consent_state;
   logic         has_pma_link, needs_fallback, checksum_ok;

   int checks = 0;
   int errors = 0;

   localparam logic [143:0] TV1 = 144'h42500000_00000001_0010_F0_2B_01_2A_0042_00_00;

   consent_header_parser dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .header_in(header_in),
      .out_valid(out_valid), .rpp_address(rpp_address), .packet_id(packet_id),
      .origin_ref(origin_ref), .theta(theta), .phi(phi), .omega(omega), .radius(radius),
      .consent_state(consent_state), .has_pma_link(has_pma_link),
      .needs_fallback(needs_fallback), .phase_entropy_index(phase_entropy_index),
      .complecount_trace(complecount_trace), .payload_type(payload_type),
      .fallback_vector(fallback_vector), .coherence_window_id(coherence_window_id),
      .phase_ref(phase_ref), .checksum_ok(checksum_ok)
   );

   always #5 clk = ~clk;

   // Snapshot of every DUT output as one 153-bit vector.
   function automatic logic [152:0] observed();
      return {out_valid, rpp_address, packet_id, origin_ref, theta, phi, omega, radius,
              consent_state, has_pma_link, needs_fallback, phase_entropy_index,
              complecount_trace, payload_type, fallback_vector, coherence_window_id,
              phase_ref, checksum_ok};
   endfunction

   // Reference model: works on an array of header bytes with plain arithmetic.
   function automatic logic [152:0] model(input logic [143:0] h, input logic v);
      int b[18];
      int x, th, ph, om, rad, cs, pma, nf, ok;
      logic [31:0] rpp, pid;
      logic [15:0] orig, cw;
      for (int i = 0; i < 18; i++) b[i] = int'(h[143-8*i -: 8]);
      x = 0;
      for (int i = 0; i < 17; i++) x = x ^ b[i];
      ok   = (x == b[17]) ? 1 : 0;
      rpp  = 32'(b[0]*16777216 + b[1]*65536 + b[2]*256 + b[3]);
      pid  = 32'(b[4]*16777216 + b[5]*65536 + b[6]*256 + b[7]);
      orig = 16'(b[8]*256 + b[9]);
      cw   = 16'(b[14]*256 + b[15]);
      th   = b[0] / 8;
      ph   = b[0] % 8;
      om   = b[1] / 32;
      rad  = (b[1] % 32) * 8 + b[2] / 32;
      cs   = b[10] / 64;
      pma  = (b[10] / 32) % 2;
      nf   = (((b[10] / 16) % 2) == 1 || cs >= 2) ? 1 : 0;
      return {v, rpp, pid, orig, 5'(th), 3'(ph), 3'(om), 8'(rad), 2'(cs), 1'(pma), 1'(nf),
              5'(b[11] / 8), 3'(b[11] % 8), 8'(b[12]), 8'(b[13]), cw, 8'(b[16]), 1'(ok)};
   endfunction

   function automatic logic [143:0] rand_hdr();
      return {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
   endfunction

   task automatic test_reset();
      logic [152:0] got;
      rst_n = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      header_in = TV1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         got = observed();
         checks++;
         if (got !== 153'd0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d got %h want 0", c, got);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== model(TV1, 1'b1)) begin
         errors++;
         $display("FAIL reset_release got %h want %h", got, model(TV1, 1'b1));
      end
      in_valid = 1'b0;
      $display("test_reset: hdr %h", TV1);
   endtask

   task automatic test_tv1();
      logic [152:0] got;
      @(negedge clk);
      in_valid = 1'b1;
      header_in = TV1;
      @(negedge clk);
      in_valid = 1'b0;
      got = observed();
      checks++;
      if (got !== model(TV1, 1'b1)) begin
         errors++;
         $display("FAIL tv1_model got %h want %h", got, model(TV1, 1'b1));
      end
      checks++;
      if ({theta, phi, omega, radius} !== {5'd8, 3'd2, 3'd2, 8'd128}) begin
         errors++;
         $display("FAIL tv1_coords got %0d/%0d/%0d/%0d want 8/2/2/128", theta, phi, omega, radius);
      end
      checks++;
      if ({consent_state, has_pma_link, needs_fallback, phase_entropy_index, complecount_trace,
           checksum_ok} !== {2'd3, 1'b1, 1'b1, 5'd5, 3'd3, 1'b0}) begin
         errors++;
         $display("FAIL tv1_flags got cs=%0d pma=%0d nf=%0d pei=%0d ct=%0d ok=%0d want 3 1 1 5 3 0",
                  consent_state, has_pma_link, needs_fallback, phase_entropy_index,
                  complecount_trace, checksum_ok);
      end
      checks++;
      if (coherence_window_id[5:0] !== 6'h02 || fallback_vector !== 8'h2A) begin
         errors++;
         $display("FAIL tv1_cw got cw=%h fv=%h want 0042 2A", coherence_window_id, fallback_vector);
      end
      $display("test_tv1: hdr %h out %h", TV1, got);
   endtask

   task automatic test_checksum_good();
      logic [143:0] h;
      logic [152:0] got;
      h = TV1;
      h[7:0] = 8'hB1;
      @(negedge clk);
      in_valid = 1'b1;
      header_in = h;
      @(negedge clk);
      in_valid = 1'b0;
      got = observed();
      checks++;
      if (checksum_ok !== 1'b1 || got !== model(h, 1'b1)) begin
         errors++;
         $display("FAIL checksum_good got ok=%0d vec %h want ok=1 vec %h", checksum_ok, got, model(h, 1'b1));
      end
      $display("test_checksum_good: hdr %h ok %0d", h, checksum_ok);
   endtask

   task automatic test_byte10();
      logic [143:0] h;
      logic [7:0] vals [2];
      logic [3:0] want [2];
      vals[0] = 8'h00; want[0] = {2'd0, 1'b0, 1'b0};
      vals[1] = 8'h80; want[1] = {2'd2, 1'b0, 1'b1};
      for (int k = 0; k < 2; k++) begin
         h = TV1;
         h[63:56] = vals[k];
         @(negedge clk);
         in_valid = 1'b1;
         header_in = h;
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if ({consent_state, has_pma_link, needs_fallback} !== want[k]) begin
            errors++;
            $display("FAIL byte10_%h got cs=%0d pma=%0d nf=%0d want %b", vals[k],
                     consent_state, has_pma_link, needs_fallback, want[k]);
         end
         $display("test_byte10: byte10 %h cs %0d nf %0d", vals[k], consent_state, needs_fallback);
      end
   endtask

   task automatic test_back_to_back();
      logic [143:0] h [3];
      logic [152:0] got;
      for (int k = 0; k < 3; k++) begin
         h[k] = rand_hdr();
         h[k][111:80] = 32'(k + 1);
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         if (k < 3) begin
            in_valid = 1'b1;
            header_in = h[k];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         got = observed();
         checks++;
         if (got !== model(h[(k < 3) ? k : 2], k < 3)) begin
            errors++;
            $display("FAIL b2b_%0d got %h want %h", k, got, model(h[(k < 3) ? k : 2], k < 3));
         end
         $display("test_back_to_back: step %0d valid %0d id %0d", k, out_valid, packet_id);
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || packet_id !== 32'd3) begin
         errors++;
         $display("FAIL b2b_idle got valid=%0d id=%0d want 0 3", out_valid, packet_id);
      end
   endtask

   task automatic test_random();
      logic [143:0] h;
      logic [152:0] exp_vec, got;
      logic v;
      int b [17];
      int x;
      exp_vec = observed() & {1'b0, {152{1'b1}}};
      exp_vec = model(header_in, 1'b0) ;
      for (int n = 0; n < 200; n++) begin
         h = rand_hdr();
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) begin
            x = 0;
            for (int i = 0; i < 17; i++) begin
               b[i] = int'(h[143-8*i -: 8]);
               x = x ^ b[i];
            end
            h[7:0] = 8'(x);
         end
         in_valid = v;
         header_in = h;
         if (v) exp_vec = model(h, 1'b1);
         else   exp_vec = {1'b0, exp_vec[151:0]};
         @(negedge clk);
         got = observed();
         checks++;
         if (got !== exp_vec) begin
            errors++;
            $display("FAIL random_%0d got %h want %h", n, got, exp_vec);
         end
         $display("test_random: %0d valid %0d hdr %h ok %0d", n, v, h, checksum_ok);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      logic [152:0] got;
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b1;
      header_in = TV1;
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== 153'd0) begin
         errors++;
         $display("FAIL reset_mid got %h want 0", got);
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== 153'd0) begin
         errors++;
         $display("FAIL reset_mid_idle got %h want 0", got);
      end
      $display("test_reset_midstream: out %h", got);
   endtask

   initial begin
      test_reset();
      test_tv1();
      test_checksum_good();
      test_byte10();
      test_back_to_back();
      test_random();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
